alu_result_stage: RTL

Execute/writeback stage directly downstream of the 16-bit ALU. Captures the ALU's combinational result and flags for each accepted operation and holds the processor status register (PSR) with per-opcode-class update masks. Feeds the PSR carry back to the ALU `carryIn` and presents register writebacks through a 2-entry valid/ready buffer to the register file.

---
 rtl/alu_pkg.sv | 89 ++++++++
 rtl/alu_result_stage_fifo.sv | 50 +++++
 rtl/alu_result_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, PSR flag positions and the
// opcode-to-class decode used by the result stage.
package alu_pkg;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_ADD    = 8'h01;
   localparam logic [7:0] OP_ADDI   = 8'h02;
   localparam logic [7:0] OP_ADDU   = 8'h03;
   localparam logic [7:0] OP_ADDUI  = 8'h04;
   localparam logic [7:0] OP_ADDC   = 8'h05;
   localparam logic [7:0] OP_ADDCI  = 8'h06;
   localparam logic [7:0] OP_ADDCU  = 8'h07;
   localparam logic [7:0] OP_ADDCUI = 8'h08;
   localparam logic [7:0] OP_SUB    = 8'h09;
   localparam logic [7:0] OP_SUBI   = 8'h0A;
   localparam logic [7:0] OP_CMP    = 8'h0B;
   localparam logic [7:0] OP_CMPI   = 8'h0C;
   localparam logic [7:0] OP_CMPU   = 8'h0D;
   localparam logic [7:0] OP_CMPUI  = 8'h0E;
   localparam logic [7:0] OP_AND    = 8'h0F;
   localparam logic [7:0] OP_ANDI   = 8'h10;
   localparam logic [7:0] OP_OR     = 8'h11;
   localparam logic [7:0] OP_ORI    = 8'h12;
   localparam logic [7:0] OP_XOR    = 8'h13;
   localparam logic [7:0] OP_XORI   = 8'h14;
   localparam logic [7:0] OP_NOT    = 8'h15;
   localparam logic [7:0] OP_LSH    = 8'h16;
   localparam logic [7:0] OP_LSHI   = 8'h17;
   localparam logic [7:0] OP_RSH    = 8'h18;
   localparam logic [7:0] OP_RSHI   = 8'h19;
   localparam logic [7:0] OP_ALSH   = 8'h1A;
   localparam logic [7:0] OP_ALSHI  = 8'h1B;
   localparam logic [7:0] OP_ARSH   = 8'h1C;
   localparam logic [7:0] OP_ARSHI  = 8'h1D;

   localparam int FLAG_Z = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_L = 1;
   localparam int FLAG_N = 0;

   localparam logic [4:0] BIT_Z = 5'b00001 << FLAG_Z;
   localparam logic [4:0] BIT_C = 5'b00001 << FLAG_C;
   localparam logic [4:0] BIT_F = 5'b00001 << FLAG_F;
   localparam logic [4:0] BIT_L = 5'b00001 << FLAG_L;
   localparam logic [4:0] BIT_N = 5'b00001 << FLAG_N;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ADDU,
      CLS_ADDS,
      CLS_CMP,
      CLS_LOGIC,
      CLS_SHIFT
   } op_class_e;

   typedef struct packed {
      op_class_e  cls;
      logic [4:0] psr_mask;
      logic       writes_back;
   } op_info_t;

   function automatic op_info_t decode_op(input logic [7:0] opcode);
      op_info_t info;
      info.cls         = CLS_NONE;
      info.psr_mask    = 5'b00000;
      info.writes_back = 1'b0;
      case (opcode)
         OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
            info.cls = CLS_ADDU;  info.psr_mask = BIT_Z | BIT_C;         info.writes_back = 1'b1;
         end
         OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI, OP_SUB, OP_SUBI: begin
            info.cls = CLS_ADDS;  info.psr_mask = BIT_Z | BIT_F;         info.writes_back = 1'b1;
         end
         OP_CMP, OP_CMPI, OP_CMPU, OP_CMPUI: begin
            info.cls = CLS_CMP;   info.psr_mask = BIT_Z | BIT_L | BIT_N; info.writes_back = 1'b0;
         end
         OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_NOT: begin
            info.cls = CLS_LOGIC; info.psr_mask = BIT_Z;                 info.writes_back = 1'b1;
         end
         OP_LSH, OP_LSHI, OP_RSH, OP_RSHI, OP_ALSH, OP_ALSHI, OP_ARSH, OP_ARSHI: begin
            info.cls = CLS_SHIFT; info.psr_mask = 5'b00000;              info.writes_back = 1'b1;
         end
         default: ;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Two-entry writeback FIFO. The head register only changes when a new entry
// becomes head, so the output holds while stalled and while empty.
module result_fifo2 #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != 2'd2);
   assign do_pop  = pop && (count != 2'd0);
   assign dout    = head;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               tail <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) head <= tail;
               count <= count - 2'd1;
            end
            // push+pop only happens at count 1: the new entry goes straight to head
            2'b11:   head <= din;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: PSR with per-class update masks plus a 2-entry writeback
// buffer. Define ALU_RESULT_PERF_EN to add saturating op/stall counters.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_opcode,
   input  logic [DEST_W-1:0] in_dest,
   input  logic [15:0]       alu_c,
   input  logic [4:0]        alu_flags,
   output logic              alu_carry_in,
   output logic [4:0]        psr,
   input  logic              psr_wr_en,
   input  logic [4:0]        psr_wr_data,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DEST_W-1:0] wb_dest,
   output logic [15:0]       wb_data
`ifdef ALU_RESULT_PERF_EN
   ,
   output logic [15:0]       perf_ops,
   output logic [15:0]       perf_stalls
`endif
);

   op_info_t  dec;
   logic      accept;
   logic      push;
   logic      pop;
   logic [1:0] count;

   assign dec          = decode_op(in_opcode);
   assign in_ready     = (count != 2'd2);
   assign accept       = in_valid && in_ready;
   assign push         = accept && dec.writes_back && (dec.cls != CLS_NONE) && !flush;
   assign wb_valid     = (count != 2'd0);
   assign pop          = wb_valid && wb_ready;
   assign alu_carry_in = psr[FLAG_C];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psr <= 5'b00000;
      end else if (psr_wr_en) begin
         psr <= psr_wr_data;
      end else if (accept) begin
         psr <= (psr & ~dec.psr_mask) | (alu_flags & dec.psr_mask);
      end
   end

   result_fifo2 #(.WIDTH(DEST_W + 16)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .din     ({in_dest, alu_c}),
      .dout    ({wb_dest, wb_data}),
      .count   (count)
   );

`ifdef ALU_RESULT_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_ops    <= 16'h0000;
         perf_stalls <= 16'h0000;
      end else begin
         if (accept && (perf_ops != 16'hFFFF))
            perf_ops <= perf_ops + 16'h0001;
         if (in_valid && !in_ready && (perf_stalls != 16'hFFFF))
            perf_stalls <= perf_stalls + 16'h0001;
      end
   end
`endif

endmodule
